ram_march_bist: RTL and testbench

- Built-in self-test controller placed directly upstream of the 16x8 single-port RAM. It drives the RAM's we/addr/datain and consumes its dataout.
- Runs a March C- style sequence (write, read-modify-write ascending, read-modify-write descending, final read) over every address.
- Reports pass/fail, the first failing address and a failure count to the system controller.
- Arbitration between functional RAM traffic and BIST traffic is done outside this block.

---
 rtl/ram_march_bist.sv | 142 ++++++++++++++
 tb/tb_ram_march_bist.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ram_march_bist.sv
// rtl/ram_march_bist.sv - March C- BIST controller for a single-port RAM
// Drives RAM we/addr/wdata directly and reports pass, first failing address and mismatch count.
module ram_march_bist #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] PATTERN = 8'h55
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [ADDR_W+1:0] fail_count
);

  typedef enum logic [3:0] {
    IDLE, W0, M1_RD, M1_WR, M2_RD, M2_WR, R0, FLUSH, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t              state;
  logic                cmp_en;
  logic [DATA_W-1:0]   cmp_exp;
  logic [ADDR_W-1:0]   cmp_addr;
  logic                mismatch;

  // R0 is pipelined: the data seen now belongs to the previous address.
  always_comb begin
    cmp_en   = 1'b0;
    cmp_exp  = PATTERN;
    cmp_addr = mem_addr;
    case (state)
      M1_WR: cmp_en = 1'b1;
      M2_WR: begin
        cmp_en  = 1'b1;
        cmp_exp = ~PATTERN;
      end
      R0: begin
        cmp_en   = (mem_addr != '0);
        cmp_addr = mem_addr - 1'b1;
      end
      FLUSH: cmp_en = 1'b1;
      default: cmp_en = 1'b0;
    endcase
    mismatch = cmp_en && (mem_rdata != cmp_exp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_addr  <= '0;
      fail_count <= '0;
    end else begin
      if (mismatch) begin
        fail_count <= fail_count + 1'b1;
        if (fail_count == '0)
          fail_addr <= cmp_addr;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= W0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_addr  <= '0;
            fail_count <= '0;
            mem_we     <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= PATTERN;
          end
        end
        W0: begin
          if (mem_addr == LAST) begin
            state    <= M1_RD;
            mem_we   <= 1'b0;
            mem_addr <= '0;
          end else begin
            mem_addr <= mem_addr + 1'b1;
          end
        end
        M1_RD: begin
          state     <= M1_WR;
          mem_we    <= 1'b1;
          mem_wdata <= ~PATTERN;
        end
        M1_WR: begin
          mem_we <= 1'b0;
          if (mem_addr == LAST) begin
            state <= M2_RD;
          end else begin
            state    <= M1_RD;
            mem_addr <= mem_addr + 1'b1;
          end
        end
        M2_RD: begin
          state     <= M2_WR;
          mem_we    <= 1'b1;
          mem_wdata <= PATTERN;
        end
        M2_WR: begin
          mem_we <= 1'b0;
          if (mem_addr == '0) begin
            state <= R0;
          end else begin
            state    <= M2_RD;
            mem_addr <= mem_addr - 1'b1;
          end
        end
        R0: begin
          if (mem_addr == LAST)
            state <= FLUSH;
          else
            mem_addr <= mem_addr + 1'b1;
        end
        FLUSH: begin
          state  <= DONE;
          busy   <= 1'b0;
          done   <= 1'b1;
          pass   <= (fail_count == '0) && !mismatch;
          mem_we <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_march_bist.sv
// tb/tb_ram_march_bist.sv - self-checking bench for ram_march_bist
// Uses a faulty-RAM model with stuck-at masks and an abstract March C- reference.
module tb_ram_march_bist;

  localparam logic [7:0] P = 8'h55;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_addr;
  logic [5:0] fail_count;

  logic [7:0] ram [16];
  logic [7:0] sa0 [16];
  logic [7:0] sa1 [16];

  int tests = 0;
  int fails = 0;

  ram_march_bist dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .pass(pass), .fail_addr(fail_addr), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  // 16x8 RAM; stuck-at faults show up on the read path
  always @(posedge clk) begin
    if (rst)
      mem_rdata <= 8'h00;
    else if (mem_we)
      ram[mem_addr] <= mem_wdata;
    else
      mem_rdata <= (ram[mem_addr] | sa1[mem_addr]) & ~sa0[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < 16; a++) begin
      sa0[a] = 8'h00;
      sa1[a] = 8'h00;
    end
  endtask

  function automatic bit read_bad(int a, logic [7:0] stored, logic [7:0] exp);
    return ((stored | sa1[a]) & ~sa0[a]) != exp;
  endfunction

  // March C- on an abstract memory: count mismatching reads, remember the first
  task automatic model(output int cnt, output int first);
    logic [7:0] m [16];
    cnt = 0;
    first = 0;
    for (int a = 0; a < 16; a++) m[a] = P;
    for (int a = 0; a < 16; a++) begin
      if (read_bad(a, m[a], P)) begin if (cnt == 0) first = a; cnt++; end
      m[a] = ~P;
    end
    for (int a = 15; a >= 0; a--) begin
      if (read_bad(a, m[a], ~P)) begin if (cnt == 0) first = a; cnt++; end
      m[a] = P;
    end
    for (int a = 0; a < 16; a++)
      if (read_bad(a, m[a], P)) begin if (cnt == 0) first = a; cnt++; end
  endtask

  task automatic run(input string tag, input bit hold);
    logic [4:0] expq [$];
    int cyc = 0;
    int bad = 0;
    int ovl = 0;
    int cnt;
    int first;
    for (int a = 0; a < 16; a++) expq.push_back({1'b1, 4'(a)});
    for (int a = 0; a < 16; a++) begin expq.push_back({1'b0, 4'(a)}); expq.push_back({1'b1, 4'(a)}); end
    for (int a = 15; a >= 0; a--) begin expq.push_back({1'b0, 4'(a)}); expq.push_back({1'b1, 4'(a)}); end
    for (int a = 0; a < 16; a++) expq.push_back({1'b0, 4'(a)});
    expq.push_back({1'b0, 4'd15});
    model(cnt, first);

    @(negedge clk) start = 1'b1;
    @(negedge clk);
    while (busy && cyc < 200) begin
      start = hold || (cyc == 20);
      if (cyc >= expq.size() || {mem_we, mem_addr} !== expq[cyc]) bad++;
      if (done) ovl++;
      cyc++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, cyc, 97);
    check({tag, " addr_trace"}, bad, 0);
    check({tag, " busy_done_overlap"}, ovl, 0);
    check({tag, " done"}, done, 1);
    check({tag, " pass"}, pass, (cnt == 0));
    check({tag, " fail_count"}, fail_count, cnt);
    check({tag, " fail_addr"}, fail_addr, first);
  endtask

  initial begin
    int bad;
    int cyc;
    rst = 1'b1;
    start = 1'b0;
    clear_faults();
    for (int a = 0; a < 16; a++) ram[a] = 8'h00;
    repeat (2) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst pass", pass, 0);
    check("rst mem_we", mem_we, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst fail_addr", fail_addr, 0);
    check("rst fail_count", fail_count, 0);
    rst = 1'b0;

    run("clean", 1'b0);
    bad = 0;
    for (int a = 0; a < 16; a++) if (ram[a] !== P) bad++;
    check("clean final_image", bad, 0);
    check("clean pass_const", {pass, fail_count, fail_addr}, {1'b1, 6'd0, 4'd0});

    sa1[5][0] = 1'b1;
    run("sa1_a5b0", 1'b0);
    check("sa1_a5b0 direct", {fail_count, fail_addr}, {6'd1, 4'd5});

    clear_faults();
    sa0[9][7] = 1'b1;
    sa0[3][7] = 1'b1;
    run("sa0_a9a3b7", 1'b0);
    check("sa0_a9a3b7 direct", {fail_count, fail_addr}, {6'd2, 4'd9});

    for (int k = 0; k < 6; k++) begin
      int n;
      clear_faults();
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) begin
        int a;
        int b;
        a = $urandom_range(0, 15);
        b = $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1) sa1[a][b] = 1'b1;
        else sa0[a][b] = 1'b1;
      end
      run($sformatf("rand%0d", k), 1'b0);
    end

    // start held through the whole run, then still high when done arrives
    clear_faults();
    sa1[5][0] = 1'b1;
    run("held", 1'b1);
    @(negedge clk);
    check("restart busy", busy, 1);
    check("restart done", done, 0);
    check("restart pass", pass, 0);
    check("restart fail_count", fail_count, 0);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin cyc++; @(negedge clk); end
    check("restart finishes", done, 1);

    // abort mid-run with a fault that has already been counted
    clear_faults();
    sa0[2][0] = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (39) @(negedge clk);
    check("pre_abort fail_count", fail_count, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort mem_we", mem_we, 0);
    check("abort mem_addr", mem_addr, 0);
    check("abort fail_count", fail_count, 0);
    clear_faults();
    run("after_abort", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
